// File: rtl/timer_prog_master.sv
// Drives the timer's 3-cycle nibble programming sequence (CTRL, MSN, LSN) from a valid/ready request.
// Define TIMER_PROG_RAW_EN to drive invalid requests onto the bus as well, for negative testing of the timer.
module timer_prog_master #(
    parameter int C0_MIN     = 2,
    parameter int C0_MAX     = 150,
    parameter int C1_MIN     = 50,
    parameter int C1_MAX     = 200,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_counter,
    input  logic [2:0] req_mode,
    input  logic [7:0] req_count,
    output logic [3:0] d,
    output logic [1:0] a,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, CTRL, MSN, LSN, GAP} state_t;

`ifdef TIMER_PROG_RAW_EN
    localparam bit RAW = 1'b1;
`else
    localparam bit RAW = 1'b0;
`endif

    localparam logic [7:0] C0_LO    = 8'(C0_MIN);
    localparam logic [7:0] C0_HI    = 8'(C0_MAX);
    localparam logic [7:0] C1_LO    = 8'(C1_MIN);
    localparam logic [7:0] C1_HI    = 8'(C1_MAX);
    localparam logic [2:0] GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    state_t     state;
    logic       c_q;
    logic [2:0] m_q;
    logic [7:0] n_q;
    logic       bad_q;
    logic [2:0] gap_cnt;
    logic       in_range;
    logic       parity_ok;
    logic       req_ok;

    always_comb begin
        in_range  = req_counter ? (req_count >= C1_LO && req_count <= C1_HI)
                                : (req_count >= C0_LO && req_count <= C0_HI);
        parity_ok = 1'b1;
        if (req_mode == 3'd2 && req_count[0])
            parity_ok = 1'b0;
        if ((req_mode == 3'd3 || req_mode == 3'd4) && !req_count[0])
            parity_ok = 1'b0;
        req_ok = (req_mode <= 3'd4) && in_range && parity_ok;
    end

    // NOTE: ready is combinational so a request presented in the reset cycle is never accepted.
    assign req_ready = (state == IDLE) && !rst;

    // NOTE: all state and bus registers use non-blocking assignments so every output updates on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a       <= 2'b11;
            d       <= 4'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            gap_cnt <= 3'd0;
            c_q     <= 1'b0;
            m_q     <= 3'd0;
            n_q     <= 8'h00;
            bad_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    a    <= 2'b11;
                    d    <= 4'h0;
                    busy <= 1'b0;
                    if (req_valid) begin
                        c_q   <= req_counter;
                        m_q   <= req_mode;
                        n_q   <= req_count;
                        bad_q <= !req_ok;
                        if (req_ok || RAW) begin
                            state <= CTRL;
                            a     <= 2'b10;
                            d     <= {req_counter, req_mode};
                            busy  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CTRL: begin
                    state <= MSN;
                    a     <= {1'b0, c_q};
                    d     <= n_q[7:4];
                end
                MSN: begin
                    state <= LSN;
                    d     <= n_q[3:0];
                end
                LSN: begin
                    a    <= 2'b11;
                    d    <= 4'h0;
                    done <= 1'b1;
                    // bad_q can only be set here when raw driving is enabled.
                    err  <= bad_q;
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= 3'd0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= 3'd0;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    a     <= 2'b11;
                    d     <= 4'h0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_prog_master.sv
// Self-checking bench for timer_prog_master: directed, boundary, random, back-to-back and reset scenarios.
// The expected bus trace per request is derived from the timer programming rules, not from the RTL's FSM.
module tb_timer_prog_master;

    localparam int GAP = 1;

`ifdef TIMER_PROG_RAW_EN
    localparam bit RAW = 1'b1;
`else
    localparam bit RAW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_counter;
    logic [2:0] req_mode;
    logic [7:0] req_count;
    logic [3:0] d;
    logic [1:0] a;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_prog_master #(
        .C0_MIN(2), .C0_MAX(150), .C1_MIN(50), .C1_MAX(200), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_counter(req_counter), .req_mode(req_mode), .req_count(req_count),
        .d(d), .a(a), .busy(busy), .done(done), .err(err)
    );

    // Legality of a request straight from the timer's programming rules.
    function automatic bit ref_ok(input int c, input int m, input int n);
        int lo;
        int hi;
        lo = (c == 1) ? 50 : 2;
        hi = (c == 1) ? 200 : 150;
        if (m > 4) return 1'b0;
        if (n < lo || n > hi) return 1'b0;
        if (m == 2 && n % 2 == 1) return 1'b0;
        if ((m == 3 || m == 4) && n % 2 == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Expected {a, d, busy, done, err, req_ready} k cycles after acceptance.
    function automatic logic [9:0] ref_cycle(input int k, input bit c, input logic [2:0] m,
                                             input logic [7:0] n, input bit ok);
        logic [3:0] hi_nib;
        logic [3:0] lo_nib;
        hi_nib = n[7:4];
        lo_nib = n[3:0];
        if (!ok && !RAW)
            return {2'b11, 4'h0, 1'b0, 1'b0, (k == 1), 1'b1};
        case (k)
            1:       return {2'b10, c, m, 1'b1, 1'b0, 1'b0, 1'b0};
            2:       return {1'b0, c, hi_nib, 1'b1, 1'b0, 1'b0, 1'b0};
            3:       return {1'b0, c, lo_nib, 1'b1, 1'b0, 1'b0, 1'b0};
            4:       return {2'b11, 4'h0, (GAP > 0), 1'b1, !ok, (GAP == 0)};
            default: return {2'b11, 4'h0, (GAP > 1), 1'b0, 1'b0, (GAP <= 1)};
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            errors++;
            $display("FAIL %s ready_timeout: req_ready=%0b required=1", tag, req_ready);
        end
    endtask

    // Presents one request, then checks the bus view for five cycles after acceptance.
    task automatic do_req(input bit c, input logic [2:0] m, input logic [7:0] n, input string tag);
        bit         ok;
        logic [9:0] exp;
        logic [9:0] obs;
        ok = ref_ok(int'(c), int'(m), int'(n));
        @(negedge clk);
        req_valid   = 1'b1;
        req_counter = c;
        req_mode    = m;
        req_count   = n;
        wait_ready(tag);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp = ref_cycle(k, c, m, n, ok);
            obs = {a, d, busy, done, err, req_ready};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle%0d {a,d,busy,done,err,ready}: got %b required %b",
                         tag, k, obs, exp);
            end
            if (k == 1) begin
                req_valid   = 1'b0;
                req_counter = 1'($urandom);
                req_mode    = 3'($urandom);
                req_count   = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_counter = 1'b0;
        req_mode  = 3'd0;
        req_count = 8'd10;
        repeat (3) @(negedge clk);
        checks++;
        if ({a, d, busy, done, err, req_ready} !== {2'b11, 4'h0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got %b required %b",
                     {a, d, busy, done, err, req_ready}, {2'b11, 4'h0, 4'b0000});
        end
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        do_req(1'b0, 3'd2, 8'd100, "c0_m2_100");
        do_req(1'b1, 3'd3, 8'd199, "c1_m3_199");
        do_req(1'b0, 3'd2, 8'd101, "c0_m2_odd");
        do_req(1'b1, 3'd0, 8'd49,  "c1_below");
        do_req(1'b0, 3'd5, 8'd20,  "mode5");
        do_req(1'b1, 3'd4, 8'd60,  "c1_m4_even");
    endtask

    task automatic test_boundaries();
        do_req(1'b0, 3'd0, 8'd2,   "c0_min");
        do_req(1'b0, 3'd0, 8'd150, "c0_max");
        do_req(1'b1, 3'd1, 8'd50,  "c1_min");
        do_req(1'b1, 3'd1, 8'd200, "c1_max");
        do_req(1'b0, 3'd0, 8'd1,   "c0_1");
        do_req(1'b0, 3'd0, 8'd151, "c0_151");
        do_req(1'b1, 3'd1, 8'd201, "c1_201");
    endtask

    task automatic test_random();
        bit         c;
        logic [2:0] m;
        logic [7:0] n;
        for (int i = 0; i < 40; i++) begin
            c = 1'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            n = 8'($urandom);
            do_req(c, m, n, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid   = 1'b1;
        req_counter = 1'b0;
        req_mode    = 3'd0;
        req_count   = 8'd10;
        wait_ready("b2b");
        @(posedge clk);
        for (int k = 1; k <= GAP + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_counter = 1'b1;
                req_mode    = 3'd1;
                req_count   = 8'd100;
            end
            if (k <= GAP + 4) begin
                checks++;
                if (req_ready !== (k == GAP + 4)) begin
                    errors++;
                    $display("FAIL b2b_ready cycle%0d: got %b required %b", k, req_ready, (k == GAP + 4));
                end
            end
            if (k == 4) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first_done: got %b required 1", done);
                end
            end
            if (k == GAP + 5) begin
                checks++;
                if ({a, d} !== {2'b10, 4'h9}) begin
                    errors++;
                    $display("FAIL b2b_second_ctrl: got a=%b d=%h required a=10 d=9", a, d);
                end
                req_valid = 1'b0;
            end
        end
        repeat (GAP + 5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid   = 1'b1;
        req_counter = 1'b1;
        req_mode    = 3'd4;
        req_count   = 8'd101;
        wait_ready("rst_mid");
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a, d} !== {2'b01, 4'h6}) begin
            errors++;
            $display("FAIL rst_mid_msn: got a=%b d=%h required a=01 d=6", a, d);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a, d, busy, done, err} !== {2'b11, 4'h0, 3'b000}) begin
            errors++;
            $display("FAIL rst_mid_idle: got %b required %b", {a, d, busy, done, err}, {2'b11, 4'h0, 3'b000});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a, done, err, req_ready} !== {2'b11, 3'b001}) begin
            errors++;
            $display("FAIL rst_mid_after: got %b required %b", {a, done, err, req_ready}, {2'b11, 3'b001});
        end
        do_req(1'b0, 3'd1, 8'd77, "post_rst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
